// File: rtl/ram_arbiter_pkg.sv
// Shared widths and FSM encoding for the two-port RAM arbiter.
package ram_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester port: request handshake plus its completion response.
interface ram_arbiter_if;
  import ram_pkg::*;

  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/single_port_ram.sv
// 64 x 8 single-port RAM with a registered read port (q valid one cycle after addr).
module single_port_ram
  import ram_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              clk,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // write port and registered read; a read in a write cycle returns old contents
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= data;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving two requesters access to one single-port RAM.
// After reset the RAM is cleared one word per cycle before any request is accepted.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   INIT  | clearing RAM, init_cnt walks 0..63 writing 8'h00; no grants
//   IDLE  | serving requests, at most one grant per cycle
module ram_arbiter
  import ram_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  m0,
  ram_arbiter_if.slave  m1,
  output logic          init_done
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic              prio;
  logic              grant0;
  logic              grant1;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;

  logic [1:0]        rsp_valid_q;
  logic              rsp_read_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: leave INIT once the last address has been cleared
  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == LAST_ADDR) begin
      state_nxt = IDLE;
    end
  end

  // FSM outputs: grant selection and RAM port steering
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = init_cnt;
    ram_data = '0;
    if (state == INIT) begin
      // gated so a held reset never writes the RAM
      ram_we = rst_n;
    end else begin
      if (m0.valid && (!m1.valid || !prio)) begin
        grant0 = 1'b1;
      end else if (m1.valid) begin
        grant1 = 1'b1;
      end
      if (grant0) begin
        ram_we   = m0.we;
        ram_addr = m0.addr;
        ram_data = m0.wdata;
      end else if (grant1) begin
        ram_we   = m1.we;
        ram_addr = m1.addr;
        ram_data = m1.wdata;
      end
    end
  end

  // clear-sequence address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end

  // round-robin pointer: after any grant, favour the other requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (grant0) begin
      prio <= 1'b1;
    end else if (grant1) begin
      prio <= 1'b0;
    end
  end

  // response tracking: who completed last cycle and whether it was a read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 2'b00;
      rsp_read_q  <= 1'b0;
    end else begin
      rsp_valid_q <= {grant1, grant0};
      rsp_read_q  <= (grant0 && !m0.we) || (grant1 && !m1.we);
    end
  end

  single_port_ram u_ram (
    .data (ram_data),
    .addr (ram_addr),
    .we   (ram_we),
    .clk  (clk),
    .q    (ram_q)
  );

  assign m0.ready     = grant0;
  assign m1.ready     = grant1;
  assign m0.rsp_valid = rsp_valid_q[0];
  assign m1.rsp_valid = rsp_valid_q[1];
  assign m0.rsp_rdata = (rsp_valid_q[0] && rsp_read_q) ? ram_q : '0;
  assign m1.rsp_rdata = (rsp_valid_q[1] && rsp_read_q) ? ram_q : '0;
  assign init_done    = (state == IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, reset sequences,
// and random traffic against a word-array / round-robin reference model.
module tb_ram_arbiter;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;

  ram_arbiter_if m0_bus ();
  ram_arbiter_if m1_bus ();

  ram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [64];
  int         ref_prio;

  typedef struct {
    bit         v0;
    bit         we0;
    logic [5:0] a0;
    logic [7:0] d0;
    bit         v1;
    bit         we1;
    logic [5:0] a1;
    logic [7:0] d1;
    bit         r0;
    bit         r1;
    bit         rv0;
    bit         rv1;
    logic [7:0] q0;
    logic [7:0] q1;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void ref_clear();
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    ref_prio = 0;
  endfunction

  // -1 none, 0 / 1 granted requester
  function automatic int ref_grant(input bit v0, input bit v1);
    if (v0 && v1) return ref_prio;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic idle_inputs();
    m0_bus.valid = 0; m0_bus.we = 0; m0_bus.addr = '0; m0_bus.wdata = '0;
    m1_bus.valid = 0; m1_bus.we = 0; m1_bus.addr = '0; m1_bus.wdata = '0;
  endtask

  // apply one cycle of requests; check ready before the edge and responses after it
  task automatic step(input vec_t v, input string tag);
    int g;
    m0_bus.valid = v.v0; m0_bus.we = v.we0; m0_bus.addr = v.a0; m0_bus.wdata = v.d0;
    m1_bus.valid = v.v1; m1_bus.we = v.we1; m1_bus.addr = v.a1; m1_bus.wdata = v.d1;
    #1;
    chk({tag, " m0_ready"}, 32'(m0_bus.ready), 32'(v.r0));
    chk({tag, " m1_ready"}, 32'(m1_bus.ready), 32'(v.r1));
    g = ref_grant(v.v0, v.v1);
    @(posedge clk);
    #1;
    chk({tag, " m0_rsp_valid"}, 32'(m0_bus.rsp_valid), 32'(v.rv0));
    chk({tag, " m1_rsp_valid"}, 32'(m1_bus.rsp_valid), 32'(v.rv1));
    chk({tag, " m0_rsp_rdata"}, 32'(m0_bus.rsp_rdata), 32'(v.q0));
    chk({tag, " m1_rsp_rdata"}, 32'(m1_bus.rsp_rdata), 32'(v.q1));
    if (g == 0 && v.we0) ref_mem[v.a0] = v.d0;
    if (g == 1 && v.we1) ref_mem[v.a1] = v.d1;
    if (g >= 0) ref_prio = (g == 0) ? 1 : 0;
  endtask

  // called at posedge+1 right after reset release; holds requests to prove none are granted
  task automatic wait_init(input string tag);
    int  n;
    bit  early_ready;
    n = 0;
    early_ready = 0;
    m0_bus.valid = 1; m0_bus.we = 1;
    m1_bus.valid = 1; m1_bus.we = 1;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done) break;
      if (m0_bus.ready || m1_bus.ready) early_ready = 1;
    end
    idle_inputs();
    chk({tag, " init_cycles"}, 32'(n), 32'd64);
    chk({tag, " ready_during_init"}, 32'(early_ready), 32'd0);
    ref_clear();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " m0_ready"}, 32'(m0_bus.ready), 32'd0);
    chk({tag, " m1_ready"}, 32'(m1_bus.ready), 32'd0);
    chk({tag, " m0_rsp_valid"}, 32'(m0_bus.rsp_valid), 32'd0);
    chk({tag, " m1_rsp_valid"}, 32'(m1_bus.rsp_valid), 32'd0);
    chk({tag, " m0_rsp_rdata"}, 32'(m0_bus.rsp_rdata), 32'd0);
    chk({tag, " m1_rsp_rdata"}, 32'(m1_bus.rsp_rdata), 32'd0);
    chk({tag, " init_done"}, 32'(init_done), 32'd0);
  endtask

  function automatic logic [5:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return 6'($urandom_range(0, 3));
    return 6'($urandom_range(0, 63));
  endfunction

  initial begin
    vec_t v;
    int   g;
    bit   early_ready;

    //            v0 we0 a0     d0     v1 we1 a1     d1     r0 r1 rv0 rv1 q0     q1
    tbl[0]  = '{1, 1, 6'd0,  8'h01, 0, 0, 6'd0,  8'h00, 1, 0, 1, 0, 8'h00, 8'h00};
    tbl[1]  = '{1, 0, 6'd0,  8'h00, 0, 0, 6'd0,  8'h00, 1, 0, 1, 0, 8'h01, 8'h00};
    tbl[2]  = '{0, 0, 6'd0,  8'h00, 1, 0, 6'd5,  8'h00, 0, 1, 0, 1, 8'h00, 8'h00};
    tbl[3]  = '{1, 1, 6'd1,  8'h02, 1, 0, 6'd1,  8'h00, 1, 0, 1, 0, 8'h00, 8'h00};
    tbl[4]  = '{1, 1, 6'd1,  8'h02, 1, 0, 6'd1,  8'h00, 0, 1, 0, 1, 8'h00, 8'h02};
    tbl[5]  = '{1, 1, 6'd1,  8'h02, 1, 0, 6'd1,  8'h00, 1, 0, 1, 0, 8'h00, 8'h00};
    tbl[6]  = '{1, 1, 6'd1,  8'h02, 1, 0, 6'd1,  8'h00, 0, 1, 0, 1, 8'h00, 8'h02};
    tbl[7]  = '{0, 0, 6'd0,  8'h00, 1, 1, 6'd1,  8'h04, 0, 1, 0, 1, 8'h00, 8'h00};
    tbl[8]  = '{0, 0, 6'd0,  8'h00, 1, 0, 6'd1,  8'h00, 0, 1, 0, 1, 8'h00, 8'h04};
    tbl[9]  = '{0, 0, 6'd0,  8'h00, 0, 0, 6'd0,  8'h00, 0, 0, 0, 0, 8'h00, 8'h00};
    tbl[10] = '{1, 0, 6'd17, 8'h00, 0, 0, 6'd0,  8'h00, 1, 0, 1, 0, 8'h00, 8'h00};
    tbl[11] = '{1, 0, 6'd63, 8'h00, 1, 1, 6'd62, 8'h5A, 0, 1, 0, 1, 8'h00, 8'h00};

    idle_inputs();
    ref_clear();

    // outputs held low while in reset, even with requests pending
    #2;
    m0_bus.valid = 1; m1_bus.valid = 1;
    #1;
    check_reset_outputs("por");
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    wait_init("init0");

    for (int i = 0; i < 12; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      v.v0  = ($urandom_range(0, 3) != 0);
      v.we0 = $urandom_range(0, 1) == 1;
      v.a0  = rand_addr();
      v.d0  = 8'($urandom);
      v.v1  = ($urandom_range(0, 3) != 0);
      v.we1 = $urandom_range(0, 1) == 1;
      v.a1  = rand_addr();
      v.d1  = 8'($urandom);
      g     = ref_grant(v.v0, v.v1);
      v.r0  = (g == 0);
      v.r1  = (g == 1);
      v.rv0 = v.r0;
      v.rv1 = v.r1;
      v.q0  = (v.r0 && !v.we0) ? ref_mem[v.a0] : 8'h00;
      v.q1  = (v.r1 && !v.we1) ? ref_mem[v.a1] : 8'h00;
      step(v, $sformatf("rnd%0d", i));
    end
    idle_inputs();

    // write 8'hFF to 63, then a read response interrupted by reset
    v = '{1, 1, 6'd63, 8'hFF, 0, 0, 6'd0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00};
    step(v, "wr63");
    v = '{1, 1, 6'd9, 8'hAB, 0, 0, 6'd0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00};
    step(v, "wr9");
    v = '{1, 0, 6'd9, 8'h00, 0, 0, 6'd0, 8'h00, 1, 0, 1, 0, 8'hAB, 8'h00};
    step(v, "rd9");
    m0_bus.valid = 1; m1_bus.valid = 1;
    rst_n = 0;
    #1;
    check_reset_outputs("idle_rst");
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1;
    wait_init("init1");
    v = '{1, 0, 6'd63, 8'h00, 0, 0, 6'd0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00};
    step(v, "rd63_cleared");
    v = '{0, 0, 6'd0, 8'h00, 1, 0, 6'd9, 8'h00, 0, 1, 0, 1, 8'h00, 8'h00};
    step(v, "rd9_cleared");

    // reset 30 cycles into the clear sequence restarts the full 64 cycles
    rst_n = 0;
    #1;
    check_reset_outputs("rst2");
    @(posedge clk);
    #1;
    rst_n = 1;
    m0_bus.valid = 1; m1_bus.valid = 1;
    early_ready = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (m0_bus.ready || m1_bus.ready || init_done) early_ready = 1;
    end
    chk("init_abort ready_or_done_early", 32'(early_ready), 32'd0);
    rst_n = 0;
    #1;
    check_reset_outputs("mid_init_rst");
    @(posedge clk);
    #1;
    rst_n = 1;
    wait_init("init2");
    v = '{1, 0, 6'd17, 8'h00, 1, 0, 6'd62, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00};
    step(v, "post_abort_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
